qs_stack_ctrl: RTL and testbench
================================

Name: qs_stack_ctrl

Overview:
- Requester-side controller for the quicksort stack command interface (cmd_vld/cmd_push/cmd_clr/cmd_pop_dat_r).
- Takes push and pop requests from the partition engines over valid/ready handshakes and issues at most one stack command per cycle.
- Tracks occupancy, arbitrates push against pop, sequences clears, and returns popped data as a registered response.

Parameters:
- W, 32, data word width; equals the stack's W.
- DEPTH, 16, number of entries the controller admits; must not exceed the stack's capacity.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- push_vld  in  1  push request
- push_dat  in  W  push data
- push_rdy  out  1  push accepted when push_vld & push_rdy
- pop_vld  in  1  pop request
- pop_rdy  out  1  pop accepted when pop_vld & pop_rdy
- pop_rsp_vld_r  out  1  popped-data valid, one-cycle pulse
- pop_rsp_dat_r  out  W  popped data
- clr  in  1  flush request, single-cycle pulse
- stk_cmd_vld  out  1  stack command valid
- stk_cmd_push  out  1  1 = push, 0 = pop
- stk_cmd_push_dat  out  W  push data to the stack
- stk_cmd_clr  out  1  stack clear
- stk_cmd_pop_dat_r  in  W  stack top-of-stack register
- stk_empty_w  in  1  stack empty flag
- stk_full_w  in  1  stack full flag
- occ_r  out  $clog2(DEPTH+1)  current occupancy
- busy_r  out  1  high while state != RUN

Behaviour:
- Reset (async assert, sync release): state = INIT, occ_r = 0, prio_r = PUSH, pop_rsp_vld_r = 0, pop_rsp_dat_r = 0, busy_r = 1.
- All stk_* outputs, push_rdy and pop_rdy are combinational and are 0 whenever rst_n = 0.
- FSM states: INIT, RUN, CLR.
  - INIT: drives stk_cmd_vld = 1 and stk_cmd_clr = 1 for exactly one cycle, then moves to RUN. push_rdy = pop_rdy = 0.
  - RUN: normal operation; busy_r = 0.
  - CLR: single settle cycle after a clear. push_rdy = pop_rdy = 0. Returns to RUN.
- clr in RUN:
  - Same cycle: stk_cmd_vld = 1, stk_cmd_clr = 1, push_rdy = pop_rdy = 0.
  - Next state: occ_r = 0, state = CLR.
  - A pop response already scheduled for the next cycle is suppressed (pop_rsp_vld_r = 0).
- clr in INIT or CLR: ignored.
- Ready equations in RUN with clr = 0 (push_rdy depends on pop_vld and vice versa; there is no combinational path from *_rdy back to *_vld):
  - push_rdy = (occ_r != DEPTH) & (~pop_vld | occ_r == 0 | prio_r == PUSH)
  - pop_rdy = (occ_r != 0) & (~push_vld | occ_r == DEPTH | prio_r == POP)
- Contention: when push_vld and pop_vld are both high and both are legal, the side named by prio_r wins. prio_r then toggles. prio_r is unchanged in all other cases.
- Push handshake:
  - Same cycle: stk_cmd_vld = 1, stk_cmd_push = 1, stk_cmd_push_dat = push_dat.
  - occ_r + 1 next cycle.
- Pop handshake:
  - Same cycle: stk_cmd_vld = 1, stk_cmd_push = 0.
  - pop_rsp_dat_r <= stk_cmd_pop_dat_r and pop_rsp_vld_r <= 1; response latency is 1 cycle.
  - occ_r - 1 next cycle.
- Response path has no backpressure. pop_rsp_dat_r holds its value until the next pop.
- At most one of push or pop is accepted per cycle. stk_cmd_vld = 0 when neither is accepted and there is no clear.
- Boundaries:
  - occ_r == DEPTH: push_rdy = 0.
  - occ_r == 0: pop_rdy = 0.
  - occ_r never wraps.
- Async reset mid-operation: all state returns to reset values immediately. The INIT clear re-synchronises the stack after release.

Optional Feature:
- Macro: QS_STACK_CTRL_CHECK_EN.
- When defined, the block adds output err_r (1 bit, reset 0, sticky until reset). err_r sets on the cycle after any of:
  - in RUN, stk_empty_w != (occ_r == 0);
  - a push is issued while stk_full_w = 1 and occ_r != DEPTH - 1.
- When not defined, err_r and its logic are absent; stk_empty_w and stk_full_w are unused (lint waived).

Test Plan:
- Reset then idle:
  - Cycle after release: stk_cmd_vld = 1 with stk_cmd_clr = 1, busy_r = 1.
  - One cycle later: busy_r = 0, occ_r = 0, push_rdy = 1, pop_rdy = 0.
- LIFO order:
  - Stimulus: push 0x11, 0x22, 0x33 on consecutive cycles, then pop 3 times.
  - Response: pop_rsp_dat_r = 0x33, 0x22, 0x11, each one cycle after its handshake; occ_r returns to 0.
- Full/empty with DEPTH = 4:
  - Push 5 times: push_rdy = 0 on the 5th, occ_r = 4.
  - Pop 5 times: pop_rdy = 0 on the 5th, no 5th response.
- Contention:
  - Setup: occ_r = 2, push_vld and pop_vld held high for 4 cycles.
  - Response: grants alternate push, pop, push, pop starting from prio_r; occ_r ends at 2.
- Clear mid-burst:
  - Setup: occ_r = 3, pop accepted on cycle t, clr on cycle t+1.
  - Response: pop_rsp_vld_r = 1 on cycle t+1; stk_cmd_clr = 1 on cycle t+1; pop_rsp_vld_r = 0 on cycle t+2; occ_r = 0 and push_rdy = pop_rdy = 0 on cycle t+2; RUN on cycle t+3.
- Async reset mid-push: deassert rst_n between clock edges with occ_r = 2 → outputs return to reset values immediately; the INIT clear is issued after release.

Source files
------------

// File: rtl/qs_stack_ctrl.sv
// Quicksort stack requester: arbitrates push/pop onto one stack command per cycle; pop response 1 cycle, commands combinational.
// Backpressure via push_rdy/pop_rdy (occupancy, priority, clear); response path has none. QS_STACK_CTRL_CHECK_EN adds err_r.
module qs_stack_ctrl #(
   parameter int W     = 32,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_vld,
   input  logic [W-1:0]               push_dat,
   output logic                       push_rdy,
   input  logic                       pop_vld,
   output logic                       pop_rdy,
   output logic                       pop_rsp_vld_r,
   output logic [W-1:0]               pop_rsp_dat_r,
   input  logic                       clr,
   output logic                       stk_cmd_vld,
   output logic                       stk_cmd_push,
   output logic [W-1:0]               stk_cmd_push_dat,
   output logic                       stk_cmd_clr,
   input  logic [W-1:0]               stk_cmd_pop_dat_r,
   input  logic                       stk_empty_w,
   input  logic                       stk_full_w,
   output logic [$clog2(DEPTH+1)-1:0] occ_r,
   output logic                       busy_r
`ifdef QS_STACK_CTRL_CHECK_EN
   ,
   output logic                       err_r
`endif
);

   localparam int OW = $clog2(DEPTH+1);
   localparam logic [OW-1:0] OCC_MAX = OW'(DEPTH);
   localparam logic PRIO_PUSH = 1'b0;

   typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_CLR} state_t;

   state_t state_r, state_nxt;
   logic   prio_r;
   logic   push_go, pop_go, clr_go, contend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= ST_INIT;
      else        state_r <= state_nxt;
   end

   always_comb begin
      state_nxt = state_r;
      case (state_r)
         ST_INIT: state_nxt = ST_RUN;
         ST_RUN:  if (clr) state_nxt = ST_CLR;
         ST_CLR:  state_nxt = ST_RUN;
         default: state_nxt = ST_INIT;
      endcase
   end

   // Everything here is gated by rst_n so the stack sees no command while reset is held.
   always_comb begin
      push_rdy         = 1'b0;
      pop_rdy          = 1'b0;
      stk_cmd_vld      = 1'b0;
      stk_cmd_push     = 1'b0;
      stk_cmd_push_dat = '0;
      stk_cmd_clr      = 1'b0;
      push_go          = 1'b0;
      pop_go           = 1'b0;
      clr_go           = 1'b0;
      contend          = 1'b0;
      if (rst_n) begin
         case (state_r)
            ST_INIT: begin
               stk_cmd_vld = 1'b1;
               stk_cmd_clr = 1'b1;
            end
            ST_RUN: begin
               if (clr) begin
                  clr_go      = 1'b1;
                  stk_cmd_vld = 1'b1;
                  stk_cmd_clr = 1'b1;
               end else begin
                  push_rdy = (occ_r != OCC_MAX) &
                             (~pop_vld | (occ_r == '0) | (prio_r == PRIO_PUSH));
                  pop_rdy  = (occ_r != '0) &
                             (~push_vld | (occ_r == OCC_MAX) | (prio_r != PRIO_PUSH));
                  push_go  = push_vld & push_rdy;
                  pop_go   = pop_vld & pop_rdy;
                  contend  = push_vld & pop_vld & (occ_r != OCC_MAX) & (occ_r != '0);
                  stk_cmd_vld      = push_go | pop_go;
                  stk_cmd_push     = push_go;
                  stk_cmd_push_dat = push_go ? push_dat : '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_r         <= '0;
         prio_r        <= PRIO_PUSH;
         pop_rsp_vld_r <= 1'b0;
         pop_rsp_dat_r <= '0;
         busy_r        <= 1'b1;
      end else begin
         busy_r        <= (state_nxt != ST_RUN);
         pop_rsp_vld_r <= pop_go;
         if (pop_go)
            pop_rsp_dat_r <= stk_cmd_pop_dat_r;
         if (contend)
            prio_r <= ~prio_r;
         if (clr_go)
            occ_r <= '0;
         else if (push_go)
            occ_r <= occ_r + OW'(1);
         else if (pop_go)
            occ_r <= occ_r - OW'(1);
      end
   end

`ifdef QS_STACK_CTRL_CHECK_EN
   // Sticky: any disagreement between local occupancy and the stack flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_r <= 1'b0;
      else if (((state_r == ST_RUN) && (stk_empty_w != (occ_r == '0))) ||
               (push_go && stk_full_w && (occ_r != OW'(DEPTH - 1))))
         err_r <= 1'b1;
   end
`else
   logic unused_stk_flags;
   assign unused_stk_flags = stk_empty_w ^ stk_full_w;
`endif

endmodule

// File: tb/tb_qs_stack_ctrl.sv
// Directed bench for qs_stack_ctrl (DEPTH = 4) with a behavioural stack and a pop-response scoreboard.
module tb_qs_stack_ctrl;
   localparam int W     = 32;
   localparam int DEPTH = 4;
   localparam int OW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          push_vld, pop_vld, clr;
   logic [W-1:0]  push_dat;
   logic          push_rdy, pop_rdy, pop_rsp_vld_r;
   logic [W-1:0]  pop_rsp_dat_r;
   logic          stk_cmd_vld, stk_cmd_push, stk_cmd_clr;
   logic [W-1:0]  stk_cmd_push_dat, stk_cmd_pop_dat_r;
   logic          stk_empty_w, stk_full_w;
   logic [OW-1:0] occ_r;
   logic          busy_r;
`ifdef QS_STACK_CTRL_CHECK_EN
   logic          err_r;
`endif

   qs_stack_ctrl #(.W(W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .push_vld(push_vld), .push_dat(push_dat), .push_rdy(push_rdy),
      .pop_vld(pop_vld), .pop_rdy(pop_rdy),
      .pop_rsp_vld_r(pop_rsp_vld_r), .pop_rsp_dat_r(pop_rsp_dat_r),
      .clr(clr),
      .stk_cmd_vld(stk_cmd_vld), .stk_cmd_push(stk_cmd_push),
      .stk_cmd_push_dat(stk_cmd_push_dat), .stk_cmd_clr(stk_cmd_clr),
      .stk_cmd_pop_dat_r(stk_cmd_pop_dat_r),
      .stk_empty_w(stk_empty_w), .stk_full_w(stk_full_w),
      .occ_r(occ_r), .busy_r(busy_r)
`ifdef QS_STACK_CTRL_CHECK_EN
      , .err_r(err_r)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural stack the controller drives
   logic [W-1:0] mem [DEPTH];
   int           sp = 0;
   always_comb begin
      stk_cmd_pop_dat_r = '0;
      if (sp > 0) stk_cmd_pop_dat_r = mem[sp-1];
   end
   assign stk_empty_w = (sp == 0);
   assign stk_full_w  = (sp == DEPTH);
   always @(posedge clk) begin
      if (stk_cmd_vld) begin
         if (stk_cmd_clr) sp <= 0;
         else if (stk_cmd_push) begin
            if (sp < DEPTH) begin
               mem[sp] <= stk_cmd_push_dat;
               sp      <= sp + 1;
            end
         end else if (sp > 0) sp <= sp - 1;
      end
   end

   int n_chk  = 0;
   int n_fail = 0;
   logic [W-1:0] exp_q [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every response must match the oldest expected pop value
   always @(negedge clk) begin
      if (pop_rsp_vld_r === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_rsp: got %0h expected no response at %0t", pop_rsp_dat_r, $time);
         end else begin
            chk("pop_rsp_dat", pop_rsp_dat_r, exp_q.pop_front());
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_push(input logic [W-1:0] v);
      push_vld = 1'b1;
      push_dat = v;
      @(negedge clk);
      chk("push_rdy", push_rdy, 1);
      chk("cmd_push", {stk_cmd_vld, stk_cmd_push, stk_cmd_clr}, 3'b110);
      chk("cmd_push_dat", stk_cmd_push_dat, v);
      tick;
      push_vld = 1'b0;
   endtask

   task automatic do_pop(input logic [W-1:0] exp);
      pop_vld = 1'b1;
      @(negedge clk);
      chk("pop_rdy", pop_rdy, 1);
      chk("cmd_pop", {stk_cmd_vld, stk_cmd_push}, 2'b10);
      exp_q.push_back(exp);
      tick;
      pop_vld = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; push_vld = 1'b0; pop_vld = 1'b0; clr = 1'b0; push_dat = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_occ", occ_r, 0);
      chk("rst_busy", busy_r, 1);
      chk("rst_cmd_vld", stk_cmd_vld, 0);
      chk("rst_rdy", {push_rdy, pop_rdy}, 2'b00);
      chk("rst_rsp", {pop_rsp_vld_r, pop_rsp_dat_r}, 0);

      // INIT clear then idle RUN
      tick;
      rst_n = 1'b1;
      @(negedge clk);
      chk("init_clr", {stk_cmd_vld, stk_cmd_clr}, 2'b11);
      chk("init_busy", busy_r, 1);
      chk("init_rdy", {push_rdy, pop_rdy}, 2'b00);
      tick;
      @(negedge clk);
      chk("idle_busy", busy_r, 0);
      chk("idle_occ", occ_r, 0);
      chk("idle_rdy", {push_rdy, pop_rdy}, 2'b10);
      chk("idle_cmd_vld", stk_cmd_vld, 0);
      tick;

      // LIFO order
      do_push(32'h11);
      do_push(32'h22);
      do_push(32'h33);
      chk("lifo_occ3", occ_r, 3);
      do_pop(32'h33);
      do_pop(32'h22);
      do_pop(32'h11);
      @(negedge clk);
      chk("lifo_occ0", occ_r, 0);
      tick;

      // Full then empty
      for (int i = 0; i < 5; i++) begin
         push_vld = 1'b1;
         push_dat = 32'(i + 1);
         @(negedge clk);
         chk("full_push_rdy", push_rdy, (i < 4) ? 1 : 0);
         tick;
      end
      push_vld = 1'b0;
      chk("full_occ", occ_r, 4);
      for (int i = 0; i < 5; i++) begin
         pop_vld = 1'b1;
         @(negedge clk);
         chk("empty_pop_rdy", pop_rdy, (i < 4) ? 1 : 0);
         if (i < 4) exp_q.push_back(32'(4 - i));
         tick;
      end
      pop_vld = 1'b0;
      chk("empty_occ", occ_r, 0);
      tick;

      // Contention from occ 2, prio starts at push
      do_push(32'hA0);
      do_push(32'hA1);
      for (int k = 0; k < 4; k++) begin
         push_vld = 1'b1;
         pop_vld  = 1'b1;
         push_dat = 32'hB0 + 32'(k);
         @(negedge clk);
         chk("cont_grant", {push_rdy, pop_rdy}, (k % 2 == 0) ? 2'b10 : 2'b01);
         if (k % 2 == 1) exp_q.push_back(32'hB0 + 32'(k) - 32'd1);
         tick;
      end
      push_vld = 1'b0;
      pop_vld  = 1'b0;
      chk("cont_occ", occ_r, 2);
      do_pop(32'hA1);
      do_pop(32'hA0);

      // Clear right after a pop
      do_push(32'hC0);
      do_push(32'hC1);
      do_push(32'hC2);
      do_pop(32'hC2);
      clr = 1'b1;
      @(negedge clk);
      chk("clr_rsp_vld", pop_rsp_vld_r, 1);
      chk("clr_cmd", {stk_cmd_vld, stk_cmd_clr, stk_cmd_push}, 3'b110);
      chk("clr_rdy", {push_rdy, pop_rdy}, 2'b00);
      tick;
      clr = 1'b0;
      @(negedge clk);
      chk("clr2_rsp_vld", pop_rsp_vld_r, 0);
      chk("clr2_occ", occ_r, 0);
      chk("clr2_rdy", {push_rdy, pop_rdy}, 2'b00);
      chk("clr2_busy", busy_r, 1);
      tick;
      @(negedge clk);
      chk("clr3_busy", busy_r, 0);
      chk("clr3_rdy", {push_rdy, pop_rdy}, 2'b10);
      tick;

      // Async reset mid-push
      do_push(32'hD0);
      do_push(32'hD1);
      push_vld = 1'b1;
      push_dat = 32'hD2;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_occ", occ_r, 0);
      chk("arst_busy", busy_r, 1);
      chk("arst_cmd_vld", stk_cmd_vld, 0);
      chk("arst_rdy", {push_rdy, pop_rdy}, 2'b00);
      chk("arst_rsp", {pop_rsp_vld_r, pop_rsp_dat_r}, 0);
      push_vld = 1'b0;
      tick;
      rst_n = 1'b1;
      @(negedge clk);
      chk("arst_init_clr", {stk_cmd_vld, stk_cmd_clr}, 2'b11);
      tick;
      @(negedge clk);
      chk("arst_run", {busy_r, pop_rdy, push_rdy}, 3'b001);
      tick;
      do_push(32'hE0);
      do_pop(32'hE0);
      repeat (2) tick;

      chk("rsp_q_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
